// File: rtl/alu_test_harness_if.sv
// Operand/result bus between the harness and the external ALU under test.
interface alu_test_harness_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] oA;
    logic [WIDTH-1:0] oB;
    logic [4:0]       oControl;
    logic [WIDTH-1:0] iResult;
    logic             iZero;

    modport master (output oA, oB, oControl, input iResult, iZero);
    modport slave  (input oA, oB, oControl, output iResult, iZero);
endinterface

// File: rtl/alu_test_harness.sv
// Board-level ALU exerciser: debounced keys load operands/opcode, capture the
// ALU result and page any word onto six seven-segment digits.
module alu_test_harness_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronized level disagrees with the stable one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync[1];
                press  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module alu_test_harness #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 iRST_n,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    alu_test_harness_if.master   alu,
    output logic [9:0]           LEDR,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);
    localparam int         PAGES     = (WIDTH + 23) / 24;
    localparam int         EXT_W     = PAGES * 24;
    localparam logic [1:0] PAGE_LAST = 2'(PAGES - 1);

    localparam logic [1:0] SHOW_R = 2'b00;
    localparam logic [1:0] SHOW_A = 2'b01;
    localparam logic [1:0] SHOW_B = 2'b10;

    logic [3:0]       press;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             fresh_a, fresh_b;
    logic [4:0]       ctl_q;
    logic             zero_q;
    logic             cap_start;
    logic [1:0]       cap_pipe;
    logic [1:0]       state, page;
    logic [WIDTH-1:0] word;
    logic [EXT_W-1:0] ext;
    logic [23:0]      window;
    logic [5:0][6:0]  hex;

    for (genvar k = 0; k < 4; k++) begin : g_key
        alu_test_harness_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (CLOCK_50),
            .rst_n (iRST_n),
            .raw   (KEY[k]),
            .press (press[k])
        );
    end

    function automatic logic [WIDTH-1:0] sext(input logic [9:0] v);
        return {{(WIDTH-10){v[9]}}, v};
    endfunction

    always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            a_q     <= '0;
            b_q     <= '0;
            fresh_a <= 1'b1;
            fresh_b <= 1'b1;
        end else if (press[0] && press[1]) begin
            a_q     <= '0;
            b_q     <= '0;
            fresh_a <= 1'b1;
            fresh_b <= 1'b1;
        end else begin
            if (press[0]) begin
                a_q     <= fresh_a ? sext(SW) : {a_q[WIDTH-11:0], SW};
                fresh_a <= 1'b0;
            end
            if (press[1]) begin
                b_q     <= fresh_b ? sext(SW) : {b_q[WIDTH-11:0], SW};
                fresh_b <= 1'b0;
            end
        end
    end

    // Opcode lands one cycle after the press, the ALU output is sampled the
    // cycle after that; a press while the opcode is settling is dropped.
    assign cap_start = press[2] & ~cap_pipe[0];

    always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            cap_pipe <= '0;
            ctl_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            cap_pipe <= {cap_pipe[0], cap_start};
            if (cap_start)   ctl_q <= SW[4:0];
            if (cap_pipe[1]) begin
                res_q  <= alu.iResult;
                zero_q <= alu.iZero;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= SHOW_R;
            page  <= '0;
        end else if (press[3]) begin
            if (page == PAGE_LAST) begin
                page <= '0;
                case (state)
                    SHOW_R:  state <= SHOW_A;
                    SHOW_A:  state <= SHOW_B;
                    default: state <= SHOW_R;
                endcase
            end else begin
                page <= page + 1'b1;
            end
        end
    end

    always_comb begin
        case (state)
            SHOW_A:  word = a_q;
            SHOW_B:  word = b_q;
            default: word = res_q;
        endcase
        ext            = '0;
        ext[WIDTH-1:0] = word;
    end

    assign window = ext[int'(page)*24 +: 24];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            hex <= {6{7'b1000000}};
        end else begin
            for (int i = 0; i < 6; i++) hex[i] <= seg7(window[4*i +: 4]);
        end
    end

    assign alu.oA       = a_q;
    assign alu.oB       = b_q;
    assign alu.oControl = ctl_q;
    assign LEDR         = {zero_q, state, page, ctl_q};
    assign HEX0         = hex[0];
    assign HEX1         = hex[1];
    assign HEX2         = hex[2];
    assign HEX3         = hex[3];
    assign HEX4         = hex[4];
    assign HEX5         = hex[5];
endmodule
